uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//   Parametrised UART receiver: next generation of the fixed 8N1 receiver used by UART_echo.
//   Configurable data width, parity, stop bits and oversampling.
//   Majority-vote sampling, framing/parity/overrun error reporting, valid/ready output handshake.
//   Sits between the board RXD pin and the echo/control logic, all on the CLK100MHZ domain.
// PARAMETERS
//   CLK_FREQ    100_000_000  input clock frequency, Hz
//   BAUD        115200       line rate, bit/s
//   OVERSAMPLE  16           sample ticks per bit; even, >=8
//   DATA_BITS   8            payload bits per frame, 5..9, LSB first
//   PARITY      0            0 = none, 1 = even, 2 = odd
//   STOP_BITS   1            1 or 2
//   Derived: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), rounded to nearest, must be >=1
//   (defaults: DIV = 54).
// PORTS
//   CLK100MHZ   in   1          system clock
//   reset       in   1          asynchronous, active-high
//   RXD         in   1          serial line, idle high, asynchronous to CLK100MHZ
//   data        out  DATA_BITS  received payload, stable while valid=1
//   valid       out  1          frame available; held until accepted
//   ready       in   1          consumer accepts when valid & ready on a rising edge
//   frame_err   out  1          qualified by valid: a stop bit was sampled 0
//   parity_err  out  1          qualified by valid: parity mismatch (always 0 when PARITY=0)
//   overrun     out  1          sticky: a frame completed while valid=1; frame dropped
//   busy        out  1          1 whenever state != IDLE
// BEHAVIOUR
//   - Reset (async, while reset=1):
//     - data, valid, frame_err, parity_err, overrun, busy = 0; state = IDLE.
//     - Both sync flops and the vote register preset to 1, so the line is read as idle.
//     - Reset mid-frame abandons the frame with no output.
//   - Input path: RXD passes 2-flop synchroniser -> rxs. The tick counter divides by DIV
//     and runs free in every state. Sample counter counts 0..OVERSAMPLE-1 per bit.
//   - Bit value: majority of rxs at sample counts OVERSAMPLE/2-1, /2, /2+1,
//     decided at count OVERSAMPLE/2+1 (the "sample point").
//   - FSM:
//     - IDLE: rxs==0 on a tick -> START; sample counter cleared.
//     - START: voted bit at sample point ==1 -> IDLE (glitch rejected, no output);
//       else continue to sample count OVERSAMPLE-1 -> DATA.
//     - DATA: shift voted bit into bit[idx], idx 0..DATA_BITS-1.
//       After the last bit -> PARITY if PARITY!=0, else -> STOP.
//     - PARITY: voted bit compared with XOR(data) (even) or ~XOR(data) (odd);
//       mismatch sets the internal perr.
//     - STOP: each stop bit voted; any 0 sets the internal ferr.
//       At the sample point of the final stop bit, the frame completes -> IDLE immediately,
//       so the next start edge may begin during the second half of the stop bit.
//   - Completion, registered one CLK100MHZ cycle after the final stop sample point:
//     - valid=0, or valid&ready in the same cycle: load data, frame_err=ferr,
//       parity_err=perr; valid=1.
//     - valid=1 and ready=0: frame discarded; data/flags unchanged; overrun=1.
//   - Handshake:
//     - valid&ready at an edge -> valid=0 on that edge.
//     - overrun clears on the same accept edge unless a new overrun occurs on that edge;
//       the new overrun wins.
//     - data/error flags are unchanged while valid=1.
//   - A break (RXD held low) gives one frame with data=0, frame_err=1, then waits in IDLE
//     until rxs returns high before a new start is recognised.
//   - DATA_BITS=9: parity covers all 9 bits. No width truncation anywhere.
// TESTING
//   Bench params: BAUD=625_000, OVERSAMPLE=16 -> DIV=10, 160 clocks per bit; 100 MHz clock.
//   1. 8N1, send 0xA5, ready=1 -> data=8'hA5, valid=1 for exactly 1 cycle, both errors=0,
//      overrun=0.
//   2. PARITY=1, send 0x07 with parity bit 0 -> data=8'h07, parity_err=1;
//      resend with parity bit 1 -> parity_err=0.
//   3. Stop bit forced 0 on 0x3C -> frame_err=1, data=8'h3C;
//      RXD held low 20 bit times -> a single frame data=0, frame_err=1, then no further valid.
//   4. ready=0, send 0x11 then 0x22 -> data stays 8'h11, overrun=1;
//      ready=1 -> valid and overrun fall together; 0x22 is never presented.
//   5. 3-clock low glitch on idle RXD -> no valid, busy returns 0 within 1 bit time;
//      reset asserted mid-frame -> all outputs 0 immediately, next clean frame 0x5A received.
//   6. Baud skew: transmitter at +/-3% bit period, DATA_BITS=7, STOP_BITS=2,
//      send 0x55 and 0x2A back-to-back -> both received correctly, no errors.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, free-running tick divider,
// 3-sample majority vote per bit, frame/parity/overrun flags and a valid/ready output.

module uart_rx_param #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIV   = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned HALF  = OVERSAMPLE / 2;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SMP_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [SMP_W-1:0]     smp_q, smp_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [1:0]           vote_q, vote_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 wait_high_q, wait_high_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic             rxs;
  logic             tick;
  logic [SMP_W-1:0] cnt;
  logic             maj;
  logic             at_sample;
  logic             at_end;
  logic             par_exp;
  logic             complete;

  assign rxs       = sync2_q;
  assign tick      = (tick_cnt_q == CNT_W'(DIV - 1));
  // cnt is the sample index this tick represents; the start-detect tick is index 0
  assign cnt       = (smp_q == SMP_W'(OVERSAMPLE - 1)) ? '0 : smp_q + 1'b1;
  assign maj       = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxs) | (vote_q[0] & rxs);
  assign at_sample = tick && (cnt == SMP_W'(HALF + 1));
  assign at_end    = tick && (cnt == SMP_W'(OVERSAMPLE - 1));
  assign par_exp   = (PARITY == 2) ? ~(^shreg_q) : ^shreg_q;

  always_comb begin
    sync1_d      = RXD;
    sync2_d      = sync1_q;
    tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
    state_d      = state_q;
    smp_d        = smp_q;
    idx_d        = idx_q;
    stop_idx_d   = stop_idx_q;
    vote_d       = vote_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    wait_high_d  = wait_high_q & ~rxs;
    data_d       = data_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    valid_d      = valid_q & ~ready;
    overrun_d    = overrun_q & ~(valid_q & ready);
    complete     = 1'b0;

    if (state_q != S_IDLE && tick) begin
      smp_d = cnt;
      if (cnt == SMP_W'(HALF - 1)) vote_d[1] = rxs;
      if (cnt == SMP_W'(HALF))     vote_d[0] = rxs;
    end

    case (state_q)
      S_IDLE: begin
        if (tick && !rxs && !wait_high_q) begin
          state_d    = S_START;
          smp_d      = '0;
          idx_d      = '0;
          stop_idx_d = 1'b0;
          vote_d     = '1;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      S_START: begin
        if (at_sample && maj) state_d = S_IDLE;
        else if (at_end)      state_d = S_DATA;
      end
      S_DATA: begin
        if (at_sample) begin
          for (int unsigned i = 0; i < DATA_BITS; i++) begin
            if (idx_q == IDX_W'(i)) shreg_d[i] = maj;
          end
        end
        if (at_end) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else                                idx_d   = idx_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (at_sample && (maj != par_exp)) perr_d = 1'b1;
        if (at_end) state_d = S_STOP;
      end
      S_STOP: begin
        // the final stop bit ends the frame at its sample point, not at bit end
        if (at_sample) begin
          if (!maj) ferr_d = 1'b1;
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (at_end) begin
          stop_idx_d = stop_idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // a held-low line must be seen high again before the next start is armed
    if (complete) begin
      wait_high_d = 1'b1;
      if (!valid_q || ready) begin
        data_d       = shreg_q;
        frame_err_d  = ferr_q | ~maj;
        parity_err_d = perr_q;
        valid_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      tick_cnt_q   <= '0;
      smp_q        <= '0;
      idx_q        <= '0;
      stop_idx_q   <= 1'b0;
      vote_q       <= '1;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      wait_high_q  <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      tick_cnt_q   <= tick_cnt_d;
      smp_q        <= smp_d;
      idx_q        <= idx_d;
      stop_idx_q   <= stop_idx_d;
      vote_q       <= vote_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      wait_high_q  <= wait_high_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations (8N1, 8E1, 7N2) at 625 kbaud,
// 16x oversampling on a 100 MHz clock, giving 160 clocks (1600 time units) per bit.

module tb_uart_rx_param;

  localparam int BT = 1600;

  typedef struct {
    int         which;
    logic [8:0] d;
    logic       pbit;
    logic       stopv;
    logic [8:0] exp_d;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [2:0] rxd;
  logic [2:0] rdy;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       v0, v1, v2, fe0, fe1, fe2, pe0, pe1, pe2, ov0, ov1, ov2, b0, b1, b2;
  logic [2:0] valid_v, fe_v, pe_v, ov_v, busy_v;
  logic [8:0] data_a [3];

  assign valid_v   = {v2, v1, v0};
  assign fe_v      = {fe2, fe1, fe0};
  assign pe_v      = {pe2, pe1, pe0};
  assign ov_v      = {ov2, ov1, ov0};
  assign busy_v    = {b2, b1, b0};
  assign data_a[0] = {1'b0, d0};
  assign data_a[1] = {1'b0, d1};
  assign data_a[2] = {2'b00, d2};

  uart_rx_param #(.CLK_FREQ(100_000_000), .BAUD(625_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .CLK100MHZ(clk), .reset(rst), .RXD(rxd[0]), .data(d0), .valid(v0), .ready(rdy[0]),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(b0));

  uart_rx_param #(.CLK_FREQ(100_000_000), .BAUD(625_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .CLK100MHZ(clk), .reset(rst), .RXD(rxd[1]), .data(d1), .valid(v1), .ready(rdy[1]),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(b1));

  uart_rx_param #(.CLK_FREQ(100_000_000), .BAUD(625_000), .OVERSAMPLE(16),
                  .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .CLK100MHZ(clk), .reset(rst), .RXD(rxd[2]), .data(d2), .valid(v2), .ready(rdy[2]),
    .frame_err(fe2), .parity_err(pe2), .overrun(ov2), .busy(b2));

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(900_000);
    $display("FAIL watchdog: time limit reached, got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input int which, input logic [8:0] d, input int nd, input bit hp,
                      input logic pb, input int ns, input logic sv, input int bt);
    rxd[which] = 1'b0;
    #(bt);
    for (int i = 0; i < nd; i++) begin
      rxd[which] = d[i];
      #(bt);
    end
    if (hp) begin
      rxd[which] = pb;
      #(bt);
    end
    for (int i = 0; i < ns; i++) begin
      rxd[which] = sv;
      #(bt);
    end
    rxd[which] = 1'b1;
  endtask

  task automatic mon(input int which, input int max_cyc, output bit seen,
                     output logic [8:0] d, output logic fe, output logic pe,
                     output logic ov, output int hi);
    seen = 1'b0; d = '0; fe = 1'b0; pe = 1'b0; ov = 1'b0; hi = 0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      @(negedge clk);
      if (valid_v[which]) begin
        seen = 1'b1;
        d    = data_a[which];
        fe   = fe_v[which];
        pe   = pe_v[which];
        ov   = ov_v[which];
      end
    end
    if (seen) begin
      hi = 1;
      while (hi < 4) begin
        @(negedge clk);
        if (!valid_v[which]) break;
        hi++;
      end
    end
  endtask

  task automatic count_valid(input int which, input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (valid_v[which]) n++;
    end
  endtask

  vec_t       vecs [9];
  bit         seen;
  logic [8:0] gd;
  logic       gfe, gpe, gov;
  int         hi, cnt, w, vc;
  bit         busy_seen;
  logic [8:0] sk_d  [2];
  logic       sk_fe [2];
  logic       sk_pe [2];
  int         skew_bt [2];

  initial begin
    vecs[0] = '{0, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{1, 9'h007, 1'b0, 1'b1, 9'h007, 1'b0, 1'b1};
    vecs[2] = '{1, 9'h007, 1'b1, 1'b1, 9'h007, 1'b0, 1'b0};
    vecs[3] = '{0, 9'h03C, 1'b0, 1'b0, 9'h03C, 1'b1, 1'b0};
    vecs[4] = '{0, 9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0};
    vecs[5] = '{1, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0};
    vecs[6] = '{1, 9'h080, 1'b0, 1'b1, 9'h080, 1'b0, 1'b1};
    vecs[7] = '{0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0};
    vecs[8] = '{1, 9'h03C, 1'b1, 1'b0, 9'h03C, 1'b1, 1'b1};
    skew_bt[0] = 1648;
    skew_bt[1] = 1552;

    rxd = '1;
    rdy = '1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_valid", 16'(valid_v), 16'h0);
    chk("reset_busy", 16'(busy_v), 16'h0);
    chk("reset_ferr", 16'(fe_v), 16'h0);
    chk("reset_perr", 16'(pe_v), 16'h0);
    chk("reset_ovr", 16'(ov_v), 16'h0);
    chk("reset_data0", 16'(d0), 16'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      w = vecs[i].which;
      fork
        send(w, vecs[i].d, 8, (w == 1), vecs[i].pbit, 1, vecs[i].stopv, BT);
        mon(w, 14 * 160, seen, gd, gfe, gpe, gov, hi);
      join
      chk($sformatf("v%0d_seen", i), 16'(seen), 16'h1);
      chk($sformatf("v%0d_data", i), 16'(gd), 16'(vecs[i].exp_d));
      chk($sformatf("v%0d_ferr", i), 16'(gfe), 16'(vecs[i].exp_fe));
      chk($sformatf("v%0d_perr", i), 16'(gpe), 16'(vecs[i].exp_pe));
      chk($sformatf("v%0d_ovr", i), 16'(gov), 16'h0);
      chk($sformatf("v%0d_valid_cycles", i), 16'(hi), 16'h1);
      #(2 * BT);
      @(negedge clk);
    end

    // break: 20 bit times low, then idle high
    cnt = 0; gd = '1; gfe = 1'b0;
    fork
      begin
        rxd[0] = 1'b0;
        #(20 * BT);
        rxd[0] = 1'b1;
        #(3 * BT);
      end
      for (int c = 0; c < 23 * 160; c++) begin
        @(negedge clk);
        if (v0) begin
          if (cnt == 0) begin
            gd  = data_a[0];
            gfe = fe0;
          end
          cnt++;
        end
      end
    join
    chk("break_frames", 16'(cnt), 16'h1);
    chk("break_data", 16'(gd), 16'h0);
    chk("break_ferr", 16'(gfe), 16'h1);

    // overrun with ready low, then a single accept
    @(negedge clk);
    rdy[0] = 1'b0;
    send(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, BT);
    #(2 * BT); @(negedge clk);
    chk("ovr_first_valid", 16'(v0), 16'h1);
    chk("ovr_first_data", 16'(d0), 16'h11);
    chk("ovr_first_flag", 16'(ov0), 16'h0);
    send(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, BT);
    #(2 * BT); @(negedge clk);
    chk("ovr_held_valid", 16'(v0), 16'h1);
    chk("ovr_held_data", 16'(d0), 16'h11);
    chk("ovr_set", 16'(ov0), 16'h1);
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("ovr_accept_valid", 16'(v0), 16'h0);
    chk("ovr_accept_flag", 16'(ov0), 16'h0);
    count_valid(0, 320, cnt);
    chk("ovr_dropped_absent", 16'(cnt), 16'h0);

    // reset mid-frame with a pending frame, error flag and overrun all set
    rdy[0] = 1'b0;
    send(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0, BT);
    #(2 * BT); @(negedge clk);
    chk("rst_pre_valid", 16'(v0), 16'h1);
    chk("rst_pre_ferr", 16'(fe0), 16'h1);
    send(0, 9'h044, 8, 1'b0, 1'b0, 1, 1'b1, BT);
    #(2 * BT); @(negedge clk);
    chk("rst_pre_ovr", 16'(ov0), 16'h1);
    fork
      send(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1, BT);
      begin
        #(4 * BT);
        chk("rst_pre_busy", 16'(b0), 16'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 16'(v0), 16'h0);
        chk("rst_mid_data", 16'(d0), 16'h0);
        chk("rst_mid_busy", 16'(b0), 16'h0);
        chk("rst_mid_ferr", 16'(fe0), 16'h0);
        chk("rst_mid_perr", 16'(pe0), 16'h0);
        chk("rst_mid_ovr", 16'(ov0), 16'h0);
      end
    join
    @(negedge clk);
    rst = 1'b0;
    rdy[0] = 1'b1;
    count_valid(0, 320, cnt);
    chk("rst_no_output", 16'(cnt), 16'h0);
    fork
      send(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1, BT);
      mon(0, 14 * 160, seen, gd, gfe, gpe, gov, hi);
    join
    chk("rst_after_seen", 16'(seen), 16'h1);
    chk("rst_after_data", 16'(gd), 16'h05A);
    chk("rst_after_ferr", 16'(gfe), 16'h0);
    #(2 * BT);

    // 3-clock glitches swept across tick phases
    vc = 0; busy_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rxd[0] = 1'b0;
      repeat (3) @(negedge clk);
      rxd[0] = 1'b1;
      for (int c = 0; c < 158; c++) begin
        @(negedge clk);
        if (v0) vc++;
        if (b0) busy_seen = 1'b1;
      end
      chk($sformatf("glitch%0d_busy", k), 16'(b0), 16'h0);
    end
    chk("glitch_no_valid", 16'(vc), 16'h0);
    chk("glitch_start_seen", 16'(busy_seen), 16'h1);

    // 7N2 back-to-back frames with transmitter at +3% and -3% bit period
    for (int s = 0; s < 2; s++) begin
      cnt = 0;
      sk_d[0] = '1; sk_d[1] = '1;
      sk_fe[0] = 1'b1; sk_fe[1] = 1'b1;
      sk_pe[0] = 1'b1; sk_pe[1] = 1'b1;
      @(negedge clk);
      fork
        begin
          send(2, 9'h055, 7, 1'b0, 1'b0, 2, 1'b1, skew_bt[s]);
          send(2, 9'h02A, 7, 1'b0, 1'b0, 2, 1'b1, skew_bt[s]);
        end
        for (int c = 0; c < 4000; c++) begin
          @(negedge clk);
          if (v2) begin
            if (cnt < 2) begin
              sk_d[cnt]  = data_a[2];
              sk_fe[cnt] = fe2;
              sk_pe[cnt] = pe2;
            end
            cnt++;
          end
        end
      join
      chk($sformatf("skew%0d_frames", s), 16'(cnt), 16'h2);
      chk($sformatf("skew%0d_data0", s), 16'(sk_d[0]), 16'h055);
      chk($sformatf("skew%0d_data1", s), 16'(sk_d[1]), 16'h02A);
      chk($sformatf("skew%0d_ferr", s), 16'({sk_fe[1], sk_fe[0]}), 16'h0);
      chk($sformatf("skew%0d_perr", s), 16'({sk_pe[1], sk_pe[0]}), 16'h0);
      chk($sformatf("skew%0d_ovr", s), 16'(ov2), 16'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
